// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 keystream/decrypt datapath.
//   prga_state_t    - per-byte sequencing states of rc4_prga_decrypt
//   ASCII_*         - bounds of the accepted plaintext character set
//   RD_WAIT_DEFAULT - default number of cycles a memory read is held
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_WAIT_I,
        ST_RD_J,
        ST_WAIT_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_WAIT_F,
        ST_WR_D,
        ST_CHECK,
        ST_DONE
    } prga_state_t;

    localparam logic [7:0] ASCII_LO = 8'h61;
    localparam logic [7:0] ASCII_HI = 8'h7A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam int RD_WAIT_DEFAULT = 2;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// rc4_prga_decrypt_if: control handshake plus the S-memory, encrypted ROM
// and plaintext RAM ports of one decrypt lane.
//   start/abort        - run request / synchronous abort (into the engine)
//   busy/done          - engine status, done is a one-cycle pulse
//   pass/fail_idx      - result of the last run
//   s_*                - S-memory read/write port
//   e_addr/e_rdata     - encrypted-message ROM port
//   d_addr/d_wdata/d_wren - plaintext RAM write port
// The slave modport is the engine side, master is the controller/memory side.
interface rc4_prga_decrypt_if #(
    parameter int K_W = 5
);
    logic           start;
    logic           abort;
    logic           busy;
    logic           done;
    logic           pass;
    logic [K_W-1:0] fail_idx;
    logic [7:0]     s_addr;
    logic [7:0]     s_wdata;
    logic           s_wren;
    logic [7:0]     s_rdata;
    logic [K_W-1:0] e_addr;
    logic [7:0]     e_rdata;
    logic [K_W-1:0] d_addr;
    logic [7:0]     d_wdata;
    logic           d_wren;

    modport master (
        output start, abort, s_rdata, e_rdata,
        input  busy, done, pass, fail_idx, s_addr, s_wdata, s_wren,
               e_addr, d_addr, d_wdata, d_wren
    );

    modport slave (
        input  start, abort, s_rdata, e_rdata,
        output busy, done, pass, fail_idx, s_addr, s_wdata, s_wren,
               e_addr, d_addr, d_wdata, d_wren
    );
endinterface

// File: rtl/rc4_char_check.sv
// rc4_char_check: combinational plaintext validity test.
//   ch    - candidate byte
//   valid - high for 'a'..'z' or space
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] ch,
    output logic       valid
);
    assign valid = ((ch >= ASCII_LO) && (ch <= ASCII_HI)) || (ch == ASCII_SP);
endmodule

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 PRGA keystream generator and message decryptor.
// Walks the encrypted ROM after the key schedule has filled S-memory, writes
// each plaintext byte to D-memory and optionally stops at the first byte
// outside the accepted character set.
//   clk, reset - clock and asynchronous active-high reset
//   bus        - control handshake and memory ports (slave side)
//
// state   | meaning
// IDLE    | waiting for start
// RD_I    | i <= i+1, address S[i]
// WAIT_I  | hold read, capture si
// RD_J    | j <= j+si, address S[j]
// WAIT_J  | hold read, capture sj
// WR_I    | write S[i] <= sj
// WR_J    | write S[j] <= si
// RD_F    | address S[si+sj] and E[k]
// WAIT_F  | hold reads, capture keystream byte and cipher byte
// WR_D    | write D[k] <= f ^ eb
// CHECK   | validate byte, finish or advance k
// DONE    | one-cycle done pulse
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN  = 32,
    parameter int RD_WAIT  = RD_WAIT_DEFAULT,
    parameter int CHECK_EN = 1,
    parameter int K_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input logic               clk,
    input logic               reset,
    rc4_prga_decrypt_if.slave bus
);
    localparam int                CNT_W    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(MSG_LEN - 1);
    localparam logic              CHK_ON   = (CHECK_EN != 0);

    prga_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       i_q, j_q, si_q, sj_q, f_q, eb_q;
    logic [K_W-1:0]   k_q;
    logic             busy_q, done_q, pass_q;
    logic [K_W-1:0]   fail_idx_q;
    logic [7:0]       s_addr_q, s_wdata_q, d_wdata_q;
    logic             s_wren_q, d_wren_q;
    logic [K_W-1:0]   e_addr_q, d_addr_q;
    logic             wait_last, last_byte, aborting, byte_ok, byte_bad;

    assign wait_last = (wait_cnt == '0);
    assign last_byte = (k_q == K_LAST);
    assign aborting  = bus.abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
    // d_wdata_q holds the byte written in WR_D, so CHECK sees the registered plaintext.
    assign byte_bad  = CHK_ON && !byte_ok;

    rc4_char_check u_char_check (
        .ch    (d_wdata_q),
        .valid (byte_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (bus.start) state_d = ST_RD_I;
                ST_RD_I:   state_d = ST_WAIT_I;
                ST_WAIT_I: if (wait_last) state_d = ST_RD_J;
                ST_RD_J:   state_d = ST_WAIT_J;
                ST_WAIT_J: if (wait_last) state_d = ST_WR_I;
                ST_WR_I:   state_d = ST_WR_J;
                ST_WR_J:   state_d = ST_RD_F;
                ST_RD_F:   state_d = ST_WAIT_F;
                ST_WAIT_F: if (wait_last) state_d = ST_WR_D;
                ST_WR_D:   state_d = ST_CHECK;
                ST_CHECK:  state_d = (byte_bad || last_byte) ? ST_DONE : ST_RD_I;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Read hold timer: loaded when the address is issued, data captured at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            case (state_q)
                ST_RD_I, ST_RD_J, ST_RD_F:
                    wait_cnt <= CNT_LOAD;
                ST_WAIT_I, ST_WAIT_J, ST_WAIT_F:
                    if (!wait_last) wait_cnt <= wait_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Outputs are registered off the current state, so busy/done lag the
    // state register by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            f_q        <= '0;
            eb_q       <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wren_q   <= 1'b0;
            e_addr_q   <= '0;
            d_addr_q   <= '0;
            d_wdata_q  <= '0;
            d_wren_q   <= 1'b0;
        end else begin
            busy_q <= (state_q != ST_IDLE);
            done_q <= (state_q == ST_DONE);
            if (aborting) begin
                s_wren_q   <= 1'b0;
                d_wren_q   <= 1'b0;
                pass_q     <= 1'b0;
                fail_idx_q <= k_q;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            i_q    <= '0;
                            j_q    <= '0;
                            k_q    <= '0;
                            pass_q <= 1'b0;
                        end
                    end
                    ST_RD_I: begin
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                    end
                    ST_WAIT_I: if (wait_last) si_q <= bus.s_rdata;
                    ST_RD_J: begin
                        j_q      <= j_q + si_q;
                        s_addr_q <= j_q + si_q;
                    end
                    ST_WAIT_J: if (wait_last) sj_q <= bus.s_rdata;
                    ST_WR_I: begin
                        s_addr_q  <= i_q;
                        s_wdata_q <= sj_q;
                        s_wren_q  <= 1'b1;
                    end
                    ST_WR_J: begin
                        s_addr_q  <= j_q;
                        s_wdata_q <= si_q;
                    end
                    ST_RD_F: begin
                        s_wren_q <= 1'b0;
                        s_addr_q <= si_q + sj_q;
                        e_addr_q <= k_q;
                    end
                    ST_WAIT_F: begin
                        if (wait_last) begin
                            f_q  <= bus.s_rdata;
                            eb_q <= bus.e_rdata;
                        end
                    end
                    ST_WR_D: begin
                        d_addr_q  <= k_q;
                        d_wdata_q <= f_q ^ eb_q;
                        d_wren_q  <= 1'b1;
                    end
                    ST_CHECK: begin
                        d_wren_q <= 1'b0;
                        if (byte_bad) begin
                            pass_q     <= 1'b0;
                            fail_idx_q <= k_q;
                        end else if (last_byte) begin
                            pass_q <= 1'b1;
                        end else begin
                            k_q <= k_q + K_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail_idx = fail_idx_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.s_wren   = s_wren_q;
    assign bus.e_addr   = e_addr_q;
    assign bus.d_addr   = d_addr_q;
    assign bus.d_wdata  = d_wdata_q;
    assign bus.d_wren   = d_wren_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt. Three lanes share clock and reset:
//   a: MSG_LEN=2, RD_WAIT=2, checking on
//   b: MSG_LEN=2, RD_WAIT=2, checking off
//   c: MSG_LEN=1, RD_WAIT=3, checking on
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] s_mem [3][256];
    logic [7:0] e_mem [3][2];
    logic [7:0] d_mem [3][2];
    int         swr_cnt [3];
    int         dwr_cnt [3];

    rc4_prga_decrypt_if #(.K_W(1)) a_if ();
    rc4_prga_decrypt_if #(.K_W(1)) b_if ();
    rc4_prga_decrypt_if #(.K_W(1)) c_if ();

    rc4_prga_decrypt #(.MSG_LEN(2), .RD_WAIT(2), .CHECK_EN(1), .K_W(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if));
    rc4_prga_decrypt #(.MSG_LEN(2), .RD_WAIT(2), .CHECK_EN(0), .K_W(1)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if));
    rc4_prga_decrypt #(.MSG_LEN(1), .RD_WAIT(3), .CHECK_EN(1), .K_W(1)) dut_c (
        .clk(clk), .reset(reset), .bus(c_if));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign a_if.s_rdata = s_mem[0][a_if.s_addr];
    assign b_if.s_rdata = s_mem[1][b_if.s_addr];
    assign c_if.s_rdata = s_mem[2][c_if.s_addr];
    assign a_if.e_rdata = e_mem[0][a_if.e_addr];
    assign b_if.e_rdata = e_mem[1][b_if.e_addr];
    assign c_if.e_rdata = e_mem[2][c_if.e_addr];

    // Memory models: identity S, cleared D and write counters on mem_init.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int m = 0; m < 3; m++) begin
                for (int n = 0; n < 256; n++) s_mem[m][n] <= 8'(n);
                d_mem[m][0] <= 8'h00;
                d_mem[m][1] <= 8'h00;
                swr_cnt[m]  <= 0;
                dwr_cnt[m]  <= 0;
            end
        end else begin
            if (a_if.s_wren) begin s_mem[0][a_if.s_addr] <= a_if.s_wdata; swr_cnt[0] <= swr_cnt[0] + 1; end
            if (b_if.s_wren) begin s_mem[1][b_if.s_addr] <= b_if.s_wdata; swr_cnt[1] <= swr_cnt[1] + 1; end
            if (c_if.s_wren) begin s_mem[2][c_if.s_addr] <= c_if.s_wdata; swr_cnt[2] <= swr_cnt[2] + 1; end
            if (a_if.d_wren) begin d_mem[0][a_if.d_addr] <= a_if.d_wdata; dwr_cnt[0] <= dwr_cnt[0] + 1; end
            if (b_if.d_wren) begin d_mem[1][b_if.d_addr] <= b_if.d_wdata; dwr_cnt[1] <= dwr_cnt[1] + 1; end
            if (c_if.d_wren) begin d_mem[2][c_if.d_addr] <= c_if.d_wdata; dwr_cnt[2] <= dwr_cnt[2] + 1; end
        end
    end

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return a_if.done;
            1:       return b_if.done;
            default: return c_if.done;
        endcase
    endfunction

    task automatic init_mems();
        @(negedge clk);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
    endtask

    // Pulses start for one cycle; e0 is the cycle count of the accepting edge.
    task automatic start_run(input int inst, output int e0);
        @(negedge clk);
        case (inst)
            0:       a_if.start = 1'b1;
            1:       b_if.start = 1'b1;
            default: c_if.start = 1'b1;
        endcase
        @(negedge clk);
        e0 = cyc;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        c_if.start = 1'b0;
    endtask

    // rise stays far out of range if done never shows, so the timing check fails.
    task automatic wait_done(input int inst, input int budget, output int rise);
        rise = -100000;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done_of(inst)) begin
                rise = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_if.busy); end
        total++; if (a_if.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", a_if.done); end
        total++; if (a_if.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", a_if.pass); end
        total++; if (a_if.s_addr !== 8'h00 || a_if.s_wren !== 1'b0 || a_if.d_wren !== 1'b0 || a_if.fail_idx !== 1'b0)
            begin bad++; $display("FAIL reset_ports got s_addr=%h s_wren=%b d_wren=%b fail_idx=%b want 0", a_if.s_addr, a_if.s_wren, a_if.d_wren, a_if.fail_idx); end
    endtask

    task automatic test_decrypt_pass();
        int e0, rise;
        init_mems();
        e_mem[0][0] = 8'h63; e_mem[0][1] = 8'h67;
        start_run(0, e0);
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL busy_at_e0 got=%b want=0", a_if.busy); end
        @(negedge clk);
        total++; if (a_if.busy !== 1'b1) begin bad++; $display("FAIL busy_at_e0p1 got=%b want=1", a_if.busy); end
        wait_done(0, 60, rise);
        total++; if (rise - e0 !== 27) begin bad++; $display("FAIL pass_done_time got=%0d want=27", rise - e0); end
        total++; if (a_if.pass !== 1'b1) begin bad++; $display("FAIL pass_flag got=%b want=1", a_if.pass); end
        @(negedge clk);
        total++; if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) begin bad++; $display("FAIL done_busy_fall got done=%b busy=%b want 0 0", a_if.done, a_if.busy); end
        total++; if (d_mem[0][0] !== 8'h61 || d_mem[0][1] !== 8'h62) begin bad++; $display("FAIL pass_plain got=%h %h want=61 62", d_mem[0][0], d_mem[0][1]); end
        total++; if (s_mem[0][2] !== 8'h03 || s_mem[0][3] !== 8'h02) begin bad++; $display("FAIL pass_swap got S2=%h S3=%h want 03 02", s_mem[0][2], s_mem[0][3]); end
        total++; if (swr_cnt[0] !== 4 || dwr_cnt[0] !== 2) begin bad++; $display("FAIL pass_wr_cycles got s=%0d d=%0d want 4 2", swr_cnt[0], dwr_cnt[0]); end
    endtask

    task automatic test_early_fail();
        int e0, rise;
        init_mems();
        e_mem[0][0] = 8'h02; e_mem[0][1] = 8'h67;
        start_run(0, e0);
        wait_done(0, 60, rise);
        total++; if (rise - e0 !== 14) begin bad++; $display("FAIL early_done_time got=%0d want=14", rise - e0); end
        total++; if (a_if.pass !== 1'b0 || a_if.fail_idx !== 1'b0) begin bad++; $display("FAIL early_result got pass=%b idx=%b want 0 0", a_if.pass, a_if.fail_idx); end
        @(negedge clk);
        total++; if (dwr_cnt[0] !== 1 || d_mem[0][0] !== 8'h00) begin bad++; $display("FAIL early_dwr got cnt=%0d d0=%h want 1 00", dwr_cnt[0], d_mem[0][0]); end
    endtask

    task automatic test_check_disabled();
        int e0, rise;
        init_mems();
        e_mem[1][0] = 8'h02; e_mem[1][1] = 8'h67;
        start_run(1, e0);
        wait_done(1, 60, rise);
        total++; if (rise - e0 !== 27) begin bad++; $display("FAIL nochk_done_time got=%0d want=27", rise - e0); end
        total++; if (b_if.pass !== 1'b1) begin bad++; $display("FAIL nochk_pass got=%b want=1", b_if.pass); end
        @(negedge clk);
        total++; if (d_mem[1][0] !== 8'h00 || d_mem[1][1] !== 8'h62 || dwr_cnt[1] !== 2)
            begin bad++; $display("FAIL nochk_plain got=%h %h cnt=%0d want=00 62 2", d_mem[1][0], d_mem[1][1], dwr_cnt[1]); end
    endtask

    task automatic test_abort();
        int e0, rise;
        init_mems();
        e_mem[0][0] = 8'h63; e_mem[0][1] = 8'h67;
        start_run(0, e0);
        repeat (17) @(negedge clk);
        a_if.abort = 1'b1;
        @(negedge clk);
        a_if.abort = 1'b0;
        wait_done(0, 30, rise);
        total++; if (rise - e0 !== 19) begin bad++; $display("FAIL abort_done_time got=%0d want=19", rise - e0); end
        total++; if (a_if.pass !== 1'b0 || a_if.fail_idx !== 1'b1) begin bad++; $display("FAIL abort_result got pass=%b idx=%b want 0 1", a_if.pass, a_if.fail_idx); end
        repeat (3) @(negedge clk);
        total++; if (swr_cnt[0] !== 2 || dwr_cnt[0] !== 1) begin bad++; $display("FAIL abort_writes got s=%0d d=%0d want 2 1", swr_cnt[0], dwr_cnt[0]); end
        total++; if (d_mem[0][0] !== 8'h61 || d_mem[0][1] !== 8'h00 || a_if.busy !== 1'b0)
            begin bad++; $display("FAIL abort_state got d=%h %h busy=%b want 61 00 0", d_mem[0][0], d_mem[0][1], a_if.busy); end
    endtask

    task automatic test_start_while_busy();
        int e0, rise;
        init_mems();
        e_mem[0][0] = 8'h63; e_mem[0][1] = 8'h67;
        start_run(0, e0);
        repeat (5) @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        wait_done(0, 60, rise);
        total++; if (rise - e0 !== 27) begin bad++; $display("FAIL busy_start_time got=%0d want=27", rise - e0); end
        repeat (3) @(negedge clk);
        total++; if (a_if.busy !== 1'b0 || a_if.pass !== 1'b1 || d_mem[0][1] !== 8'h62)
            begin bad++; $display("FAIL busy_start_state got busy=%b pass=%b d1=%h want 0 1 62", a_if.busy, a_if.pass, d_mem[0][1]); end
    endtask

    // start held through DONE: second run starts one cycle after IDLE on a
    // permuted S (S2=3, S3=2), so byte 0 decodes to 0x60 and fails early.
    task automatic test_back_to_back();
        int e0, rise1, rise2;
        init_mems();
        e_mem[0][0] = 8'h63; e_mem[0][1] = 8'h67;
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        wait_done(0, 60, rise1);
        total++; if (rise1 - e0 !== 27) begin bad++; $display("FAIL b2b_first_time got=%0d want=27", rise1 - e0); end
        @(negedge clk);
        a_if.start = 1'b0;
        total++; if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin bad++; $display("FAIL b2b_gap got busy=%b done=%b want 0 0", a_if.busy, a_if.done); end
        wait_done(0, 60, rise2);
        total++; if (rise2 - e0 !== 42) begin bad++; $display("FAIL b2b_second_time got=%0d want=42", rise2 - e0); end
        total++; if (a_if.pass !== 1'b0 || a_if.fail_idx !== 1'b0) begin bad++; $display("FAIL b2b_result got pass=%b idx=%b want 0 0", a_if.pass, a_if.fail_idx); end
        @(negedge clk);
        total++; if (d_mem[0][0] !== 8'h60) begin bad++; $display("FAIL b2b_plain got=%h want=60", d_mem[0][0]); end
    endtask

    task automatic test_reset_mid_run();
        int e0;
        init_mems();
        e_mem[0][0] = 8'h63; e_mem[0][1] = 8'h67;
        start_run(0, e0);
        repeat (6) @(negedge clk);
        total++; if (a_if.s_addr !== 8'h01 || a_if.busy !== 1'b1) begin bad++; $display("FAIL mid_pre got s_addr=%h busy=%b want 01 1", a_if.s_addr, a_if.busy); end
        reset = 1'b1;
        #1;
        total++; if (a_if.busy !== 1'b0 || a_if.s_addr !== 8'h00 || a_if.s_wren !== 1'b0 || a_if.pass !== 1'b0)
            begin bad++; $display("FAIL mid_reset got busy=%b s_addr=%h s_wren=%b pass=%b want 0 00 0 0", a_if.busy, a_if.s_addr, a_if.s_wren, a_if.pass); end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (a_if.busy !== 1'b0 || swr_cnt[0] !== 0 || dwr_cnt[0] !== 0)
            begin bad++; $display("FAIL mid_idle got busy=%b s=%0d d=%0d want 0 0 0", a_if.busy, swr_cnt[0], dwr_cnt[0]); end
    endtask

    task automatic test_rd_wait3();
        int e0, rise;
        init_mems();
        e_mem[2][0] = 8'h63; e_mem[2][1] = 8'h00;
        start_run(2, e0);
        wait_done(2, 60, rise);
        total++; if (rise - e0 !== 17) begin bad++; $display("FAIL rw3_done_time got=%0d want=17", rise - e0); end
        total++; if (c_if.pass !== 1'b1) begin bad++; $display("FAIL rw3_pass got=%b want=1", c_if.pass); end
        @(negedge clk);
        total++; if (d_mem[2][0] !== 8'h61 || dwr_cnt[2] !== 1) begin bad++; $display("FAIL rw3_plain got=%h cnt=%0d want=61 1", d_mem[2][0], dwr_cnt[2]); end
    endtask

    initial begin
        reset      = 1'b1;
        mem_init   = 1'b1;
        a_if.start = 1'b0; a_if.abort = 1'b0;
        b_if.start = 1'b0; b_if.abort = 1'b0;
        c_if.start = 1'b0; c_if.abort = 1'b0;
        for (int m = 0; m < 3; m++) begin
            e_mem[m][0] = 8'h00;
            e_mem[m][1] = 8'h00;
        end
        repeat (3) @(negedge clk);
        test_reset();
        reset    = 1'b0;
        mem_init = 1'b0;
        test_decrypt_pass();
        test_early_fail();
        test_check_disabled();
        test_abort();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_rd_wait3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
